trena_serial_controller: RTL and testbench

//  Sequencer sitting directly downstream of the HC-SR04 interface. Periodically pulses that block's

---
 rtl/trena_serial_controller.sv | 151 +++++++++++++++
 tb/tb_trena_serial_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/trena_serial_controller.sv
// Measure-and-report sequencer: triggers the HC-SR04 block, captures its BCD result and streams 3 digits + separator.
// Latency: frame ends 4*(2+tx latency)+2 cycles after capture; waits on tx_pronto per character (no timeout on the transmitter).
module trena_serial_controller #(
  parameter int         PERIODO     = 50_000_000,
  parameter int         TIMEOUT_MED = 2_500_000,
  parameter logic [6:0] SEPARADOR   = 7'h23
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ligar,
  input  logic        pronto_medida,
  input  logic [11:0] medida,
  output logic        medir,
  output logic        tx_partida,
  output logic [6:0]  tx_dados,
  input  logic        tx_pronto,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  localparam int PW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
  localparam int TW = (TIMEOUT_MED > 1) ? $clog2(TIMEOUT_MED) : 1;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    MEDE        = 4'd1,
    AGUARDA_MED = 4'd2,
    REGISTRA    = 4'd3,
    ABORTA      = 4'd4,
    TRANSMITE   = 4'd5,
    AGUARDA_TX  = 4'd6,
    PROXIMO     = 4'd7,
    FIM         = 4'd8,
    ESPERA      = 4'd9
  } estado_t;

  estado_t         estado, proximo;
  logic [1:0]      idx, idx_n;
  logic [11:0]     valor, valor_n;
  logic            abortou, abortou_n;
  logic [TW-1:0]   cnt_med, cnt_med_n;
  logic [PW-1:0]   cnt_per, cnt_per_n;
  logic [6:0]      char_n;

  function automatic logic [6:0] digito(input logic [3:0] n, input logic ab);
    if (ab)
      return 7'h2D;
    else if (n > 4'd9)
      return 7'h3F;
    else
      return 7'h30 + {3'b000, n};
  endfunction

  always_comb begin
    proximo   = estado;
    idx_n     = idx;
    valor_n   = valor;
    abortou_n = abortou;
    cnt_med_n = cnt_med;
    cnt_per_n = cnt_per;
    case (estado)
      INICIAL:     if (ligar) proximo = MEDE;
      MEDE: begin
        cnt_med_n = '0;
        proximo   = AGUARDA_MED;
      end
      AGUARDA_MED: begin
        if (cnt_med != '1) cnt_med_n = cnt_med + 1'b1;
        // medida is only guaranteed valid alongside the strobe, so latch it here
        if (pronto_medida) begin
          valor_n = medida;
          proximo = REGISTRA;
        end else if (cnt_med == TW'(TIMEOUT_MED - 1)) begin
          proximo = ABORTA;
        end
      end
      REGISTRA: begin
        abortou_n = 1'b0;
        idx_n     = 2'd0;
        proximo   = TRANSMITE;
      end
      ABORTA: begin
        abortou_n = 1'b1;
        idx_n     = 2'd0;
        proximo   = TRANSMITE;
      end
      TRANSMITE:   proximo = AGUARDA_TX;
      AGUARDA_TX:  if (tx_pronto) proximo = PROXIMO;
      PROXIMO: begin
        if (idx == 2'd3) begin
          proximo = FIM;
        end else begin
          idx_n   = idx + 2'd1;
          proximo = TRANSMITE;
        end
      end
      FIM: begin
        cnt_per_n = '0;
        proximo   = ligar ? ESPERA : INICIAL;
      end
      ESPERA: begin
        if (cnt_per != '1) cnt_per_n = cnt_per + 1'b1;
        if (!ligar)
          proximo = INICIAL;
        else if (cnt_per == PW'(PERIODO - 1))
          proximo = MEDE;
      end
      default:     proximo = INICIAL;
    endcase
  end

  // Character for the index being entered, so tx_dados is ready on the partida cycle
  always_comb begin
    char_n = SEPARADOR;
    case (idx_n)
      2'd0: char_n = digito(valor_n[11:8], abortou_n);
      2'd1: char_n = digito(valor_n[7:4],  abortou_n);
      2'd2: char_n = digito(valor_n[3:0],  abortou_n);
      2'd3: char_n = SEPARADOR;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado     <= INICIAL;
      idx        <= 2'd0;
      valor      <= 12'h000;
      abortou    <= 1'b0;
      cnt_med    <= '0;
      cnt_per    <= '0;
      medir      <= 1'b0;
      tx_partida <= 1'b0;
      pronto     <= 1'b0;
      tx_dados   <= 7'h00;
    end else begin
      estado     <= proximo;
      idx        <= idx_n;
      valor      <= valor_n;
      abortou    <= abortou_n;
      cnt_med    <= cnt_med_n;
      cnt_per    <= cnt_per_n;
      medir      <= (proximo == MEDE);
      tx_partida <= (proximo == TRANSMITE);
      pronto     <= (proximo == FIM);
      if (proximo == TRANSMITE) tx_dados <= char_n;
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_trena_serial_controller.sv
// Directed bench for trena_serial_controller with a 10-cycle transmitter responder.
module tb_trena_serial_controller;

  logic        clock;
  logic        reset;
  logic        ligar;
  logic        pronto_medida;
  logic [11:0] medida;
  logic        medir;
  logic        tx_partida;
  logic [6:0]  tx_dados;
  logic        tx_pronto;
  logic        pronto;
  logic [3:0]  db_estado;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pronto_cnt = 0;
  int a, m1, m2, m3;
  logic tx_en = 1'b0;
  logic [6:0] chars[$];
  int medir_q[$];

  trena_serial_controller #(.PERIODO(100), .TIMEOUT_MED(50), .SEPARADOR(7'h23)) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .pronto_medida(pronto_medida),
    .medida(medida), .medir(medir), .tx_partida(tx_partida), .tx_dados(tx_dados),
    .tx_pronto(tx_pronto), .pronto(pronto), .db_estado(db_estado)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (medir) medir_q.push_back(cyc);
    if (pronto) pronto_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter model: tx_pronto sampled 10 cycles after the partida cycle
  initial begin
    logic [6:0] first;
    tx_pronto = 1'b0;
    forever begin
      @(negedge clock);
      if (tx_en && tx_partida) begin
        first = tx_dados;
        chars.push_back(tx_dados);
        repeat (10) @(negedge clock);
        check("tx_hold", {25'd0, tx_dados}, {25'd0, first});
        tx_pronto = 1'b1;
        @(negedge clock);
        tx_pronto = 1'b0;
      end
    end
  end

  task automatic wait_state(input logic [3:0] code, input int budget, input string tag);
    int n;
    n = 0;
    while (db_estado !== code && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, {28'd0, db_estado}, {28'd0, code});
  endtask

  task automatic check_frame(input string tag, input logic [6:0] c0, input logic [6:0] c1,
                             input logic [6:0] c2, input logic [6:0] c3);
    logic [6:0] exp [4];
    exp[0] = c0; exp[1] = c1; exp[2] = c2; exp[3] = c3;
    check({tag, "_len"}, chars.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_c%0d", tag, i), (i < chars.size()) ? {25'd0, chars[i]} : 32'hDEAD,
            {25'd0, exp[i]});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; ligar = 1'b0; pronto_medida = 1'b0; medida = 12'h000;
    repeat (3) @(negedge clock);
    check("rst_medir", medir, 0);
    check("rst_partida", tx_partida, 0);
    check("rst_pronto", pronto, 0);
    check("rst_dados", tx_dados, 0);
    check("rst_estado", db_estado, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_estado", db_estado, 0);

    // 1: reset in the middle of AGUARDA_TX
    ligar = 1'b1;
    wait_state(4'd1, 5, "t1_mede");
    check("t1_medir", medir, 1);
    @(negedge clock);
    pronto_medida = 1'b1; medida = 12'h123;
    @(negedge clock);
    pronto_medida = 1'b0;
    wait_state(4'd6, 5, "t1_agtx");
    check("t1_dados", tx_dados, 7'h31);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    check("t1_rst_medir", medir, 0);
    check("t1_rst_partida", tx_partida, 0);
    check("t1_rst_pronto", pronto, 0);
    check("t1_rst_dados", tx_dados, 0);
    check("t1_rst_estado", db_estado, 0);
    @(negedge clock);
    reset = 1'b0;
    medir_q.delete();
    @(negedge clock);
    check("t1_restart_estado", db_estado, 1);
    check("t1_restart_medir", medir, 1);
    m1 = cyc;

    // 2: normal frame 123
    tx_en = 1'b1; chars.delete(); pronto_cnt = 0;
    @(negedge clock);
    pronto_medida = 1'b1; medida = 12'h123; a = cyc;
    @(negedge clock);
    pronto_medida = 1'b0;
    wait_state(4'd8, 100, "t2_fim");
    check("t2_pronto", pronto, 1);
    check("t2_latency", cyc - a, 50);
    check_frame("t2", 7'h31, 7'h32, 7'h33, 7'h23);
    @(negedge clock);
    check("t2_pronto_cnt", pronto_cnt, 1);
    check("t2_espera", db_estado, 9);
    check("t2_pronto_low", pronto, 0);

    // 3 + 5: no measurement -> abort frame; check medir spacing
    chars.delete();
    wait_state(4'd1, 120, "t5_mede2");
    m2 = cyc;
    check("t5_period1", m2 - m1, 152);
    repeat (50) @(negedge clock);
    check("t3_still_wait", db_estado, 2);
    @(negedge clock);
    check("t3_aborta", db_estado, 4);
    wait_state(4'd8, 100, "t3_fim");
    check("t3_frame_len", cyc - m2, 100);
    check_frame("t3", 7'h2D, 7'h2D, 7'h2D, 7'h23);

    // 4: non-BCD tens digit
    chars.delete();
    wait_state(4'd1, 120, "t4_mede");
    m3 = cyc;
    check("t5_period2", m3 - m2, 201);
    @(negedge clock);
    pronto_medida = 1'b1; medida = 12'h0A9;
    @(negedge clock);
    pronto_medida = 1'b0;
    wait_state(4'd8, 100, "t4_fim");
    check_frame("t4", 7'h30, 7'h3F, 7'h39, 7'h23);
    check("t5_medir_count", medir_q.size(), 3);

    // 6a: drop ligar during ESPERA
    @(negedge clock);
    check("t6_espera", db_estado, 9);
    repeat (5) @(negedge clock);
    ligar = 1'b0;
    @(negedge clock);
    check("t6_inicial", db_estado, 0);
    medir_q.delete();
    repeat (120) @(negedge clock);
    check("t6_no_medir", medir_q.size(), 0);
    check("t6_idle", db_estado, 0);

    // 6b: drop ligar during TRANSMITE; frame must still complete
    chars.delete(); pronto_cnt = 0;
    ligar = 1'b1;
    wait_state(4'd1, 5, "t6b_mede");
    @(negedge clock);
    pronto_medida = 1'b1; medida = 12'h456;
    @(negedge clock);
    pronto_medida = 1'b0;
    wait_state(4'd5, 5, "t6b_tx");
    ligar = 1'b0;
    medir_q.delete();
    wait_state(4'd8, 100, "t6b_fim");
    check_frame("t6b", 7'h34, 7'h35, 7'h36, 7'h23);
    @(negedge clock);
    check("t6b_inicial", db_estado, 0);
    check("t6b_pronto_cnt", pronto_cnt, 1);
    repeat (150) @(negedge clock);
    check("t6b_no_medir", medir_q.size(), 0);
    check("t6b_idle", db_estado, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
